// File: rtl/stopwatch_defs.sv
// -----------------------------------------------------------------------------
// stopwatch_defs
// Shared definitions for the stopwatch controller: FSM state encodings,
// default parameter values, the count width and the count-advance helper.
// No ports (package).
// -----------------------------------------------------------------------------
package stopwatch_defs;

    // Default timing/limit values for a 50 MHz system clock.
    localparam int DEF_TICK_CYCLES     = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_MAX_COUNT       = 99;

    // Width of the displayed count.
    localparam int CNT_W = 8;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Next count value on a tick: wraps to zero after the maximum.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] max_v);
        logic [CNT_W-1:0] nxt;
        if (cur == max_v) begin
            nxt = {CNT_W{1'b0}};
        end else begin
            nxt = cur + CNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_debounce_module.sv
// -----------------------------------------------------------------------------
// key_debounce_module
// Synchronizes, debounces and edge-detects one active-low raw pushbutton.
// Ports:
//   CLK      in   system clock, rising edge
//   RST_N    in   synchronous active-low reset
//   Key_N    in   raw active-low key, asynchronous and bouncing
//   Press    out  registered one-cycle pulse on an accepted press (1->0)
// -----------------------------------------------------------------------------
module key_debounce_module #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic Key_N,
    output logic Press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          press_q, press_d;

    // Next-state logic for synchronizer, stability counter and press detect.
    always_comb begin
        sync1_d = Key_N;
        sync2_d = sync1_q;
        // The counter tracks how many consecutive samples have disagreed with
        // the accepted level; a sample matching the level restarts it.
        if (sync2_q == level_q) begin
            cnt_d   = {CW{1'b0}};
            level_d = level_q;
        end else if (cnt_q == DB_LAST) begin
            cnt_d   = {CW{1'b0}};
            level_d = sync2_q;
        end else begin
            cnt_d   = cnt_q + CW'(1);
            level_d = level_q;
        end
        press_d = level_q & ~level_d;
    end

    // State registers; key path resets to the released level.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= {CW{1'b0}};
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign Press = press_q;

endmodule

// File: rtl/stopwatch_ctrl_module.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_module
// Start/pause/clear stopwatch: two debounced keys drive an IDLE/RUN/PAUSE FSM,
// a prescaler divides CLK down to count ticks, and an 8-bit counter wraps
// from MAX_COUNT to 0.
// Ports:
//   CLK          in   system clock, rising edge
//   RST_N        in   synchronous active-low reset
//   Key_Start    in   raw active-low start/pause key
//   Key_Clear    in   raw active-low clear key
//   Number_Data  out  registered count 0..MAX_COUNT
//   Run_Sig      out  registered, high while in RUN
//   Wrap_Pulse   out  registered one-cycle pulse after MAX_COUNT->0
// -----------------------------------------------------------------------------
module stopwatch_ctrl_module
    import stopwatch_defs::*;
#(
    parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MAX_COUNT       = DEF_MAX_COUNT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Key_Start,
    input  logic             Key_Clear,
    output logic [CNT_W-1:0] Number_Data,
    output logic             Run_Sig,
    output logic             Wrap_Pulse
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_COUNT);

    logic             start_ev_s;
    logic             clear_ev_s;
    logic             tick_s;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             run_q,   run_d;
    logic             wrap_q,  wrap_d;

    key_debounce_module #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_start (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Key_N (Key_Start),
        .Press (start_ev_s)
    );

    key_debounce_module #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_clear (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Key_N (Key_Clear),
        .Press (clear_ev_s)
    );

    // FSM next state; clear dominates a simultaneous start.
    always_comb begin
        state_d = state_q;
        if (clear_ev_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = start_ev_s ? ST_RUN   : ST_IDLE;
                ST_RUN:   state_d = start_ev_s ? ST_PAUSE : ST_RUN;
                ST_PAUSE: state_d = start_ev_s ? ST_RUN   : ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler and counter next values; PAUSE holds both.
    always_comb begin
        tick_s  = (state_q == ST_RUN) && (presc_q == TICK_LAST);
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear_ev_s || (state_q == ST_IDLE)) begin
            presc_d = {PW{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else if (state_q == ST_RUN) begin
            presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
            if (tick_s) begin
                count_d = cnt_next(count_q, CNT_MAX);
                wrap_d  = (count_q == CNT_MAX);
            end else begin
                count_d = count_q;
            end
        end else begin
            presc_d = presc_q;
            count_d = count_q;
        end
        run_d = (state_d == ST_RUN);
    end

    // Control registers; reset overrides every event in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            presc_q <= {PW{1'b0}};
            count_q <= {CNT_W{1'b0}};
            run_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            run_q   <= run_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Number_Data = count_q;
    assign Run_Sig     = run_q;
    assign Wrap_Pulse  = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl_module.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl_module
// Scoreboard bench: expected output changes (cycle, value) are queued when
// stimulus is scheduled and popped whenever an output changes.
// Key press pushed low right after edge E: synchronized low visible for the
// sample at E+3, fourth consecutive low sample accepted at E+6 (press pulse),
// FSM/Run_Sig update at E+7.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl_module;

    localparam int TICK = 10;
    localparam int DB   = 4;
    localparam int MAXC = 99;
    localparam int PRESS_LAT = 7;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_start;
    logic       key_clear;
    logic [7:0] number_data;
    logic       run_sig;
    logic       wrap_pulse;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    bit   mon_en = 1'b0;
    exp_t nd_q[$];
    exp_t run_q[$];
    exp_t wrap_q[$];

    stopwatch_ctrl_module #(
        .TICK_CYCLES     (TICK),
        .DEBOUNCE_CYCLES (DB),
        .MAX_COUNT       (MAXC)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .Key_Start   (key_start),
        .Key_Clear   (key_clear),
        .Number_Data (number_data),
        .Run_Sig     (run_sig),
        .Wrap_Pulse  (wrap_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int t);
        if (cyc > t) chk("schedule", cyc, t);
        while (cyc < t) step(1);
    endtask

    // Drive keys low right after edge t-PRESS_LAT so the FSM moves at edge t.
    task automatic press_at(input int t, input bit st, input bit cl);
        wait_cyc(t - PRESS_LAT);
        if (st) key_start = 1'b0;
        if (cl) key_clear = 1'b0;
        step(8);
        key_start = 1'b1;
        key_clear = 1'b1;
    endtask

    function automatic exp_t mk(input int c, input int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    // Output monitor: every change must match the head of its queue.
    initial begin
        logic [7:0] last_nd;
        logic       last_run;
        logic       last_wrap;
        exp_t       e;
        last_nd   = 8'd0;
        last_run  = 1'b0;
        last_wrap = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (number_data !== last_nd) begin
                    if (nd_q.size() == 0) begin
                        chk("nd_extra", number_data, last_nd);
                    end else begin
                        e = nd_q.pop_front();
                        chk("nd_val", number_data, e.val);
                        chk("nd_cyc", cyc, e.cyc);
                    end
                    last_nd = number_data;
                end
                if (run_sig !== last_run) begin
                    if (run_q.size() == 0) begin
                        chk("run_extra", run_sig, last_run);
                    end else begin
                        e = run_q.pop_front();
                        chk("run_val", run_sig, e.val);
                        chk("run_cyc", cyc, e.cyc);
                    end
                    last_run = run_sig;
                end
                if (wrap_pulse !== last_wrap) begin
                    if (wrap_q.size() == 0) begin
                        chk("wrap_extra", wrap_pulse, last_wrap);
                    end else begin
                        e = wrap_q.pop_front();
                        chk("wrap_val", wrap_pulse, e.val);
                        chk("wrap_cyc", cyc, e.cyc);
                    end
                    last_wrap = wrap_pulse;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got cycle %0d, want finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int e0, r, p, q, t, s, x;
        rst_n     = 1'b0;
        key_start = 1'b1;
        key_clear = 1'b1;
        step(3);
        chk("rst_nd", number_data, 8'd0);
        chk("rst_run", run_sig, 1'b0);
        chk("rst_wrap", wrap_pulse, 1'b0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(10);

        // Bouncy start: 3 low, 1 high, 10 low -> one event.
        // Low samples at e0+3..5 are broken by a high; 4 lows from e0+7 accept at e0+10.
        e0 = cyc;
        r  = e0 + 11;
        run_q.push_back(mk(r, 1));
        for (int n = 1; n <= MAXC; n++) nd_q.push_back(mk(r + TICK * n, n));
        nd_q.push_back(mk(r + TICK * (MAXC + 1), 0));
        wrap_q.push_back(mk(r + TICK * (MAXC + 1), 1));
        wrap_q.push_back(mk(r + TICK * (MAXC + 1) + 1, 0));
        key_start = 1'b0;
        step(3);
        key_start = 1'b1;
        step(1);
        key_start = 1'b0;
        step(10);
        key_start = 1'b1;

        // Pause 3 cycles into the period of value 1, hold 50, resume.
        p = r + TICK * (MAXC + 2) + 3;
        q = p + 50;
        nd_q.push_back(mk(r + TICK * (MAXC + 2), 1));
        run_q.push_back(mk(p, 0));
        run_q.push_back(mk(q, 1));
        for (int k = 2; k <= 42; k++) nd_q.push_back(mk(q + 7 + TICK * (k - 2), k));
        press_at(p, 1'b1, 1'b0);
        press_at(q, 1'b1, 1'b0);

        // Simultaneous start and clear while running at 42 -> IDLE.
        t = q + 7 + TICK * 40 + 5;
        nd_q.push_back(mk(t, 0));
        run_q.push_back(mk(t, 0));
        press_at(t, 1'b1, 1'b1);

        // Run to 57, then reset for one edge.
        s = q + 440;
        run_q.push_back(mk(s, 1));
        for (int n = 1; n <= 57; n++) nd_q.push_back(mk(s + TICK * n, n));
        nd_q.push_back(mk(s + 575, 0));
        run_q.push_back(mk(s + 575, 0));
        press_at(s, 1'b1, 1'b0);
        wait_cyc(s + 574);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mid_rst_nd", number_data, 8'd0);
        chk("mid_rst_run", run_sig, 1'b0);
        chk("mid_rst_wrap", wrap_pulse, 1'b0);
        step(30);
        chk("post_rst_idle", run_sig, 1'b0);

        // Key held low through reset release -> exactly one event.
        key_start = 1'b0;
        rst_n     = 1'b0;
        step(3);
        rst_n = 1'b1;
        x = cyc;
        run_q.push_back(mk(x + PRESS_LAT, 1));
        for (int n = 1; n <= 3; n++) nd_q.push_back(mk(x + PRESS_LAT + TICK * n, n));
        wait_cyc(x + 40);
        chk("held_run", run_sig, 1'b1);
        chk("held_nd", number_data, 8'd3);
        key_start = 1'b1;

        chk("nd_q_left", nd_q.size(), 0);
        chk("run_q_left", run_q.size(), 0);
        chk("wrap_q_left", wrap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
